issue_queue_allocator: RTL



---
 rtl/SchedulerTypes.sv | 18 +
 rtl/free_entry_picker.sv | 41 ++++
 rtl/issue_queue_allocator.sv | 100 ++++++++++
 3 files changed

// File: rtl/SchedulerTypes.sv
`default_nettype none
// ============================================================================
// Module   : SchedulerTypes
// Brief    : Shared scheduler constants and issue-queue datapath types.
// Revision : 1.0 - initial release
// ============================================================================
package SchedulerTypes;

    localparam int ISSUE_QUEUE_ENTRY_NUM   = 16;
    localparam int DISPATCH_WIDTH          = 2;
    localparam int ISSUE_QUEUE_INDEX_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);

    typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]   IssueQueueOneHotPath;
    typedef logic [ISSUE_QUEUE_INDEX_WIDTH:0]   IssueQueueCountPath;

endpackage
`default_nettype wire

// File: rtl/free_entry_picker.sv
`default_nettype none
// ============================================================================
// Module   : free_entry_picker
// Brief    : Chain of lane priority encoders; each requesting lane takes the
//            lowest free entry left over by the lanes below it.
// Revision : 1.0 - initial release
// ============================================================================
module free_entry_picker #(
    parameter int ENTRY_NUM = SchedulerTypes::ISSUE_QUEUE_ENTRY_NUM,
    parameter int LANE_NUM  = SchedulerTypes::DISPATCH_WIDTH
) (
    input  logic [ENTRY_NUM-1:0]         freeVector,
    input  logic [LANE_NUM-1:0]          laneReq,
    output logic [$clog2(ENTRY_NUM)-1:0] lanePtr [LANE_NUM],
    output logic [ENTRY_NUM-1:0]         allocMask
);

    localparam int                   c_IDX_W = $clog2(ENTRY_NUM);
    localparam logic [ENTRY_NUM-1:0] c_ONE   = ENTRY_NUM'(1);

    logic [ENTRY_NUM-1:0] w_avail;
    logic [ENTRY_NUM-1:0] w_pick;

    // x & -x isolates the lowest set bit; picked bits are masked out for later lanes
    always_comb begin
        w_avail   = freeVector;
        w_pick    = '0;
        allocMask = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            w_pick     = laneReq[i] ? (w_avail & (~w_avail + c_ONE)) : '0;
            w_avail    = w_avail & ~w_pick;
            allocMask  = allocMask | w_pick;
            lanePtr[i] = '0;
            for (int j = 0; j < ENTRY_NUM; j++) begin
                lanePtr[i] = lanePtr[i] | (w_pick[j] ? c_IDX_W'(j) : '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue_allocator.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_allocator
// Brief    : Free-bitmap issue-queue entry allocator with all-or-nothing grant
//            and multi-entry release per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue_allocator #(
    parameter int ISSUE_QUEUE_ENTRY_NUM = SchedulerTypes::ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH        = SchedulerTypes::DISPATCH_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     stall,
    input  logic [DISPATCH_WIDTH-1:0]                allocReq,
    output logic                                     allocGrant,
    output logic [$clog2(ISSUE_QUEUE_ENTRY_NUM)-1:0] allocPtr [DISPATCH_WIDTH],
    input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0]         releaseVector,
    output logic [$clog2(ISSUE_QUEUE_ENTRY_NUM):0]   freeCount,
    output logic                                     full,
    output logic                                     empty,
    output logic                                     releaseError
);

    localparam int c_N     = ISSUE_QUEUE_ENTRY_NUM;
    localparam int c_W     = DISPATCH_WIDTH;
    localparam int c_IDX_W = $clog2(c_N);
    localparam int c_CNT_W = c_IDX_W + 1;

    logic [c_N-1:0]     r_freeVector;
    logic [c_CNT_W-1:0] r_freeCount;
    logic               r_releaseError;

    logic [c_IDX_W-1:0] w_lanePtr [c_W];
    logic [c_N-1:0]     w_pickMask;
    logic [c_N-1:0]     w_allocMask;
    logic [c_N-1:0]     w_nextFree;
    logic [c_CNT_W-1:0] w_reqCount;
    logic [c_CNT_W-1:0] w_nextCount;
    logic               w_grant;
    logic               w_commit;

    free_entry_picker #(
        .ENTRY_NUM (c_N),
        .LANE_NUM  (c_W)
    ) u_picker (
        .freeVector (r_freeVector),
        .laneReq    (allocReq),
        .lanePtr    (w_lanePtr),
        .allocMask  (w_pickMask)
    );

    always_comb begin
        w_reqCount = '0;
        for (int i = 0; i < c_W; i++) begin
            w_reqCount = w_reqCount + c_CNT_W'(allocReq[i]);
        end
    end

    // Grant is all-or-nothing so the picker never needs a partial-grant path
    assign w_grant     = (w_reqCount <= r_freeCount);
    assign w_commit    = w_grant && !stall && (|allocReq);
    assign w_allocMask = w_commit ? w_pickMask : '0;

    // Release is OR-ed last so it wins over a (never legal) overlapping allocation
    assign w_nextFree = (r_freeVector & ~w_allocMask) | releaseVector;

    always_comb begin
        w_nextCount = '0;
        for (int j = 0; j < c_N; j++) begin
            w_nextCount = w_nextCount + c_CNT_W'(w_nextFree[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freeVector   <= '1;
            r_freeCount    <= c_CNT_W'(c_N);
            r_releaseError <= 1'b0;
        end else begin
            r_freeVector   <= w_nextFree;
            r_freeCount    <= w_nextCount;
            r_releaseError <= |(releaseVector & r_freeVector);
        end
    end

    always_comb begin
        for (int i = 0; i < c_W; i++) begin
            allocPtr[i] = (w_grant && allocReq[i]) ? w_lanePtr[i] : '0;
        end
    end

    assign allocGrant   = w_grant;
    assign freeCount    = r_freeCount;
    assign full         = (r_freeCount < c_CNT_W'(c_W));
    assign empty        = (r_freeCount == c_CNT_W'(c_N));
    assign releaseError = r_releaseError;

endmodule
`default_nettype wire
